pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Control-flow redirect controller sitting between the jump (JAL) unit, the branch unit, the trap logic and the fetch stage. It accepts redirect requests from the three sources and arbitrates simultaneous ones (trap > branch > jump). It checks target alignment, holds the pipeline in a fixed-length flush, and then loads the new PC into fetch with a ready handshake. It is the only block allowed to change the fetch PC non-sequentially.

## Interface

Parameters:
- PC_W, 8, PC/target width (matches core PC width)
- FLUSH_CYCLES, 2, cycles oFLUSH is held per redirect; legal range 1..15

Ports:
- iCLK  in  1  core clock
- iRST  in  1  synchronous reset, active-high
- iJ_REQ  in  1  jump unit redirect request
- iJ_TARGET  in  PC_W  jump target (iPC + J-immediate)
- oJ_ACK  out  1  jump request accepted this cycle
- iB_REQ  in  1  taken-branch redirect request
- iB_TARGET  in  PC_W  branch target
- oB_ACK  out  1  branch request accepted this cycle
- iT_REQ  in  1  trap redirect request
- iT_VECTOR  in  PC_W  trap vector
- oT_ACK  out  1  trap request accepted this cycle
- oFLUSH  out  1  kill younger instructions in IF/ID/EX
- oPC_LOAD  out  1  new PC valid for fetch
- oPC_NEXT  out  PC_W  PC to load
- iFETCH_RDY  in  1  fetch consumes oPC_NEXT at this edge
- oBUSY  out  1  controller not IDLE
- oMISALIGN  out  1  one-cycle pulse: misaligned jump/branch target rejected
- oMISALIGN_ADDR  out  PC_W  last rejected target, held until next rejection

## Operation

- States: IDLE, FLUSH, LOAD.
- Requester protocol: hold iX_REQ and the target stable until oX_ACK. Transfer occurs at an edge where req & ack are both high. Deassert or present a new request the following cycle.
- ACKs are combinational from state and requests. All other outputs are registered and Moore-derived.
- IDLE: the highest-priority asserted request gets ACK (at most one ACK per cycle).
  - Trap winner: target = {iT_VECTOR[PC_W-1:2], 2'b00}; go to FLUSH.
  - Jump/branch winner with target[1:0] == 0: latch target; go to FLUSH.
  - Jump/branch winner with target[1:0] != 0: ACK anyway, oMISALIGN = 1 next cycle, oMISALIGN_ADDR = target, stay IDLE. No flush and no PC load.
- FLUSH: oFLUSH = 1; a down-counter runs FLUSH_CYCLES cycles, then LOAD.
  - Only iT_REQ is ACKed in FLUSH, and only if the in-flight redirect is not a trap. A trap preempts: target is replaced, the counter restarts at FLUSH_CYCLES, and the state stays FLUSH.
  - J/B requests in FLUSH are not ACKed and remain pending.
- LOAD: oPC_LOAD = 1, oPC_NEXT = latched target. Both are held stable until iFETCH_RDY = 1, then IDLE.
  - No ACKs in LOAD.
- oBUSY = (state != IDLE).
- Reset: state IDLE, counter 0. oFLUSH, oPC_LOAD, oBUSY and oMISALIGN are 0. oPC_NEXT and oMISALIGN_ADDR are 0. ACKs are 0 because the state is IDLE with no requests.
- Reset during FLUSH/LOAD abandons the redirect. The requester already holds its ACK and does not retry.

## Timing

- Request accepted at edge k (IDLE):
  - oFLUSH is high in cycles k+1 .. k+FLUSH_CYCLES.
  - oPC_LOAD first rises in cycle k+FLUSH_CYCLES+1.
- With iFETCH_RDY tied high, LOAD lasts 1 cycle and IDLE resumes at k+FLUSH_CYCLES+2. Back-to-back redirect throughput is therefore FLUSH_CYCLES+2 cycles.
- Trap preemption accepted at edge m: oFLUSH is held through m+FLUSH_CYCLES, and LOAD is entered at m+FLUSH_CYCLES+1.
- Misaligned rejection: oMISALIGN is high only in cycle k+1. A new request can be ACKed in cycle k+1.
- oPC_NEXT never changes while oPC_LOAD = 1 and iFETCH_RDY = 0.

## Structure

- Shared package holds:
  - the state enum (IDLE/FLUSH/LOAD, 2-bit)
  - source IDs (SRC_JUMP, SRC_BRANCH, SRC_TRAP)
  - the PC_W default
  - the alignment mask constant
- One sub-module, redirect_prio_enc: a combinational fixed-priority encoder. It takes the three reqs and an enable mask and produces one-hot grant plus source ID, and is reused by the future interrupt controller.
- Flush counter width: $clog2(FLUSH_CYCLES+1).

## Test plan

- Jump only: iJ_REQ, iJ_TARGET = 8'h40, FLUSH_CYCLES = 2, iFETCH_RDY = 1 -> oJ_ACK at edge 0, oFLUSH in cycles 1-2, oPC_LOAD with oPC_NEXT = 8'h40 in cycle 3, oBUSY low in cycle 4.
- Simultaneous J (8'h40), B (8'h80), T (8'h10) in IDLE:
  - oT_ACK only; load 8'h10.
  - B is ACKed on the first IDLE cycle after, and loads 8'h80.
  - J is ACKed last.
- Misaligned jump iJ_TARGET = 8'h42 -> oJ_ACK, oMISALIGN pulse one cycle, oMISALIGN_ADDR = 8'h42, no oFLUSH, no oPC_LOAD.
- Branch to 8'h80 accepted, trap iT_VECTOR = 8'h13 in the second flush cycle:
  - oT_ACK; flush extended by 2 more cycles.
  - oPC_NEXT = 8'h10; branch target is never loaded.
- LOAD stall: iFETCH_RDY low for 3 cycles -> oPC_LOAD/oPC_NEXT stable for 4 cycles; no ACK to a pending iJ_REQ until IDLE.
- iRST asserted in FLUSH -> next cycle all outputs 0, state IDLE; a pending iB_REQ is ACKed in the first cycle after iRST drops.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller and its priority encoder.
//   state_e     : controller FSM state (idle / flush / load)
//   src_e       : redirect source identifiers, also used as request-vector bit positions
//   PcWDefault  : default PC / target width
//   AlignMask   : low PC bits that must be zero for a legal jump/branch target
package pc_redirect_ctrl_pkg;

  localparam int unsigned PcWDefault = 8;
  localparam int unsigned NumSrc     = 3;
  localparam logic [1:0]  AlignMask  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StLoad  = 2'd2
  } state_e;

  // Values double as bit positions in request/grant vectors.
  typedef enum logic [1:0] {
    SRC_JUMP   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_TRAP   = 2'd2
  } src_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect bus between the requesters (jump, branch, trap), the fetch stage and the
// redirect controller.
//   slave  : the controller (takes requests and iFETCH_RDY, drives ACKs and fetch outputs)
//   master : the requesters / fetch side
interface pc_redirect_ctrl_if
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PcWDefault
);

  logic            iJ_REQ;
  logic [PC_W-1:0] iJ_TARGET;
  logic            oJ_ACK;
  logic            iB_REQ;
  logic [PC_W-1:0] iB_TARGET;
  logic            oB_ACK;
  logic            iT_REQ;
  logic [PC_W-1:0] iT_VECTOR;
  logic            oT_ACK;
  logic            oFLUSH;
  logic            oPC_LOAD;
  logic [PC_W-1:0] oPC_NEXT;
  logic            iFETCH_RDY;
  logic            oBUSY;
  logic            oMISALIGN;
  logic [PC_W-1:0] oMISALIGN_ADDR;

  modport slave (
    input  iJ_REQ, iJ_TARGET, iB_REQ, iB_TARGET, iT_REQ, iT_VECTOR, iFETCH_RDY,
    output oJ_ACK, oB_ACK, oT_ACK, oFLUSH, oPC_LOAD, oPC_NEXT, oBUSY,
           oMISALIGN, oMISALIGN_ADDR
  );

  modport master (
    output iJ_REQ, iJ_TARGET, iB_REQ, iB_TARGET, iT_REQ, iT_VECTOR, iFETCH_RDY,
    input  oJ_ACK, oB_ACK, oT_ACK, oFLUSH, oPC_LOAD, oPC_NEXT, oBUSY,
           oMISALIGN, oMISALIGN_ADDR
  );

endinterface

// File: rtl/redirect_prio_enc.sv
// Combinational fixed-priority encoder: trap > branch > jump.
//   req_i   : request per source (bit index = src_e value)
//   en_i    : per-source enable mask; disabled requests are ignored
//   gnt_o   : one-hot grant (all zero when nothing eligible)
//   src_o   : source ID of the winner (SRC_JUMP when none)
//   valid_o : some enabled request is granted
module redirect_prio_enc
  import pc_redirect_ctrl_pkg::*;
(
  input  logic [NumSrc-1:0] req_i,
  input  logic [NumSrc-1:0] en_i,
  output logic [NumSrc-1:0] gnt_o,
  output src_e              src_o,
  output logic              valid_o
);

  logic [NumSrc-1:0] req_en;

  always_comb begin
    req_en  = req_i & en_i;
    gnt_o   = '0;
    src_o   = SRC_JUMP;
    valid_o = 1'b0;
    if (req_en[2]) begin
      gnt_o[2] = 1'b1;
      src_o    = SRC_TRAP;
      valid_o  = 1'b1;
    end else if (req_en[1]) begin
      gnt_o[1] = 1'b1;
      src_o    = SRC_BRANCH;
      valid_o  = 1'b1;
    end else if (req_en[0]) begin
      gnt_o[0] = 1'b1;
      src_o    = SRC_JUMP;
      valid_o  = 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect controller. Arbitrates jump/branch/trap redirects, rejects
// misaligned jump/branch targets, holds a fixed-length flush and then presents the new
// PC to fetch until it is consumed.
//   iCLK, iRST : clock, synchronous active-high reset
//   bus        : redirect bus (slave side) - requests/ACKs, flush, PC load handshake,
//                busy and misalignment report
// ACKs are combinational from state and requests; every other output is a register.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = PcWDefault,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic               iCLK,
  input logic               iRST,
  pc_redirect_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic              trap_q, trap_d;       // in-flight redirect is a trap
  logic              flush_q, flush_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic [PC_W-1:0]   pc_next_q, pc_next_d;
  logic              mis_q, mis_d;
  logic [PC_W-1:0]   mis_addr_q, mis_addr_d;

  logic [NumSrc-1:0] req, en, gnt;
  src_e              src;
  logic              gnt_vld;
  logic [PC_W-1:0]   win_tgt;
  logic              win_misaligned;

  assign req = {bus.iT_REQ, bus.iB_REQ, bus.iJ_REQ};

  // Only a trap may preempt a flush, and never another trap.
  always_comb begin
    en = '0;
    unique case (state_q)
      StIdle:  en = '1;
      StFlush: en = trap_q ? 3'b000 : 3'b100;
      default: en = '0;
    endcase
  end

  redirect_prio_enc u_prio_enc (
    .req_i   (req),
    .en_i    (en),
    .gnt_o   (gnt),
    .src_o   (src),
    .valid_o (gnt_vld)
  );

  assign bus.oJ_ACK = gnt[0];
  assign bus.oB_ACK = gnt[1];
  assign bus.oT_ACK = gnt[2];

  // Trap vectors are force-aligned; jump/branch targets are checked instead.
  always_comb begin
    win_tgt = bus.iJ_TARGET;
    unique case (src)
      SRC_TRAP:   win_tgt = bus.iT_VECTOR & ~PC_W'(AlignMask);
      SRC_BRANCH: win_tgt = bus.iB_TARGET;
      default:    win_tgt = bus.iJ_TARGET;
    endcase
  end

  assign win_misaligned = (src != SRC_TRAP) && ((win_tgt[1:0] & AlignMask) != 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    trap_d     = trap_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          if (win_misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = win_tgt;
          end else begin
            state_d = StFlush;
            cnt_d   = FlushInit;
            tgt_d   = win_tgt;
            trap_d  = (src == SRC_TRAP);
          end
        end
      end
      StFlush: begin
        if (gnt_vld) begin
          // Trap preemption: new target, flush restarts from the top.
          cnt_d  = FlushInit;
          tgt_d  = win_tgt;
          trap_d = 1'b1;
        end else if (cnt_q == CntW'(1)) begin
          state_d = StLoad;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StLoad: begin
        if (bus.iFETCH_RDY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    flush_d   = (state_d == StFlush);
    load_d    = (state_d == StLoad);
    busy_d    = (state_d != StIdle);
    pc_next_d = (state_d == StLoad) ? tgt_d : pc_next_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tgt_q      <= '0;
      trap_q     <= 1'b0;
      flush_q    <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      pc_next_q  <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      trap_q     <= trap_d;
      flush_q    <= flush_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      pc_next_q  <= pc_next_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign bus.oFLUSH         = flush_q;
  assign bus.oPC_LOAD       = load_q;
  assign bus.oBUSY          = busy_q;
  assign bus.oPC_NEXT       = pc_next_q;
  assign bus.oMISALIGN      = mis_q;
  assign bus.oMISALIGN_ADDR = mis_addr_q;

endmodule
